ddr_path_owner_ctl: RTL and testbench

- Ownership controller for the shared DDR AXI master port, which three sources use: memory scrubber (SCRB), traffic generator (ATG) and host slave path (SLV).
- Replaces raw enable-driven muxing with drain-before-switch sequencing, so no in-flight burst is split across owners.
- Drives the downstream mux select and an address-channel gate.
- Tracks outstanding write bursts, pending W data and outstanding read bursts by snooping the muxed port.

---
 rtl/ddr_path_owner_pkg.sv | 24 ++
 rtl/axi_outs_cnt.sv | 33 +++
 rtl/ddr_path_owner_ctl.sv | 154 +++++++++++++++
 tb/tb_ddr_path_owner_ctl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_path_owner_pkg.sv
// Shared types for the DDR master-port ownership controller.
// Owner encoding doubles as the downstream mux select value.
package ddr_path_owner_pkg;

  typedef enum logic [1:0] {
    OWN_SLV  = 2'd0,
    OWN_ATG  = 2'd1,
    OWN_SCRB = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    ST_OWN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  // Fixed priority: scrubber over traffic generator over host slave path.
  function automatic owner_t pick_target(input logic scrb_req, input logic atg_req);
    if (scrb_req) return OWN_SCRB;
    if (atg_req)  return OWN_ATG;
    return OWN_SLV;
  endfunction

endpackage

// File: rtl/axi_outs_cnt.sv
// Saturating up/down counter for outstanding AXI transactions.
// Simultaneous inc and dec cancel; dec at zero holds and flags underflow.
module axi_outs_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         underflow
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic is_zero;

  assign is_zero   = (count == '0);
  assign at_max    = (count == CNT_MAX);
  assign underflow = dec & ~inc & is_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc & ~dec & ~at_max) begin
      count <= count + 1'b1;
    end else if (dec & ~inc & ~is_zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ddr_path_owner_ctl.sv
// Ownership controller for the shared DDR AXI master port: drains all
// in-flight bursts of the current owner before moving the mux select.
module ddr_path_owner_ctl
  import ddr_path_owner_pkg::*;
#(
  parameter int OUTS_W        = 8,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int TO_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrb_req,
  input  logic              atg_req,
  // Snooped muxed port: a beat transfers only in a cycle where both valid
  // and ready are high; valid/ready levels alone never change any count.
  input  logic              awvalid,
  input  logic              awready,
  input  logic              wvalid,
  input  logic              wready,
  input  logic              wlast,
  input  logic              bvalid,
  input  logic              bready,
  input  logic              arvalid,
  input  logic              arready,
  input  logic              rvalid,
  input  logic              rready,
  input  logic              rlast,
  input  logic              err_clr,
  output logic [1:0]        owner,
  output logic              addr_block,
  output logic              scrb_grant,
  output logic              atg_grant,
  output logic              busy,
  output logic              drain_err,
  output logic              proto_err,
  output logic [OUTS_W-1:0] wr_outs,
  output logic [OUTS_W-1:0] rd_outs,
  output state_t            dbg_state
);

  localparam logic [TO_W-1:0] TMO_VAL  = TO_W'(DRAIN_TIMEOUT);
  localparam logic [TO_W-1:0] TMO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, target;
  logic [TO_W-1:0]   timer_q;
  logic [OUTS_W-1:0] w_pend;

  logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
  logic wr_max, wp_max, rd_max;
  logic wr_uf, wp_uf, rd_uf;
  logic drained, any_max, drain_hit;

  assign aw_hs     = awvalid & awready;
  assign w_last_hs = wvalid & wready & wlast;
  assign b_hs      = bvalid & bready;
  assign ar_hs     = arvalid & arready;
  assign r_last_hs = rvalid & rready & rlast;

  assign target = pick_target(scrb_req, atg_req);

  axi_outs_cnt #(.W(OUTS_W)) u_wr_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (aw_hs),
    .dec       (b_hs),
    .count     (wr_outs),
    .at_max    (wr_max),
    .underflow (wr_uf)
  );

  axi_outs_cnt #(.W(OUTS_W)) u_wp_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (aw_hs),
    .dec       (w_last_hs),
    .count     (w_pend),
    .at_max    (wp_max),
    .underflow (wp_uf)
  );

  axi_outs_cnt #(.W(OUTS_W)) u_rd_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ar_hs),
    .dec       (r_last_hs),
    .count     (rd_outs),
    .at_max    (rd_max),
    .underflow (rd_uf)
  );

  assign drained = (wr_outs == '0) && (w_pend == '0) && (rd_outs == '0);
  assign any_max = wr_max | wp_max | rd_max;

  // Next-state logic; a withdrawn request beats an empty pipe in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OWN: begin
        if (target != owner_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (target == owner_q) state_d = ST_OWN;
        else if (drained)      state_d = ST_SWITCH;
      end
      ST_SWITCH: state_d = ST_OWN;
      default:   state_d = ST_OWN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OWN;
    else        state_q <= state_d;
  end

  // The target seen in SWITCH wins, even if it changed during DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     owner_q <= OWN_SLV;
    else if (state_q == ST_SWITCH)  owner_q <= target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state_q == ST_DRAIN) begin
      if (timer_q != TMO_VAL) timer_q <= timer_q + 1'b1;
    end else begin
      timer_q <= '0;
    end
  end

  assign drain_hit = (state_q == ST_DRAIN) && (timer_q == TMO_LAST);

  // Sticky flags: a set event in the same cycle as err_clr keeps the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (drain_hit)    drain_err <= 1'b1;
      else if (err_clr) drain_err <= 1'b0;
      if (wr_uf | wp_uf | rd_uf) proto_err <= 1'b1;
      else if (err_clr)          proto_err <= 1'b0;
    end
  end

  assign owner      = owner_q;
  assign addr_block = any_max | (state_q != ST_OWN);
  assign busy       = (state_q != ST_OWN);
  assign scrb_grant = (state_q == ST_OWN) && (owner_q == OWN_SCRB);
  assign atg_grant  = (state_q == ST_OWN) && (owner_q == OWN_ATG);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ddr_path_owner_ctl.sv
// Bench for ddr_path_owner_ctl: directed scenarios plus random traffic,
// every cycle compared against a transaction-level ownership model.
module tb_ddr_path_owner_ctl;
  import ddr_path_owner_pkg::*;

  localparam int OUTS_W = 8;
  localparam int TMO    = 16;
  localparam int MAXC   = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scrb_req = 0, atg_req = 0, err_clr = 0;
  logic awvalid = 0, awready = 0, wvalid = 0, wready = 0, wlast = 0;
  logic bvalid = 0, bready = 0, arvalid = 0, arready = 0;
  logic rvalid = 0, rready = 0, rlast = 0;
  logic [1:0] owner;
  logic addr_block, scrb_grant, atg_grant, busy, drain_err, proto_err;
  logic [OUTS_W-1:0] wr_outs, rd_outs;
  state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integer counts, a phase number and a drain age.
  int m_wr, m_wp, m_rd, m_owner, m_phase, m_age;
  bit m_derr, m_perr;

  ddr_path_owner_ctl #(.OUTS_W(OUTS_W), .DRAIN_TIMEOUT(TMO), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .scrb_req(scrb_req), .atg_req(atg_req),
    .awvalid(awvalid), .awready(awready), .wvalid(wvalid), .wready(wready),
    .wlast(wlast), .bvalid(bvalid), .bready(bready), .arvalid(arvalid),
    .arready(arready), .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .err_clr(err_clr), .owner(owner), .addr_block(addr_block),
    .scrb_grant(scrb_grant), .atg_grant(atg_grant), .busy(busy),
    .drain_err(drain_err), .proto_err(proto_err), .wr_outs(wr_outs),
    .rd_outs(rd_outs), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int tgt();
    return scrb_req ? 2 : (atg_req ? 1 : 0);
  endfunction

  function automatic bit m_block();
    return (m_phase != 0) || (m_wr == MAXC) || (m_wp == MAXC) || (m_rd == MAXC);
  endfunction

  function automatic int next_cnt(input int c, input bit up, input bit dn);
    if (up && !dn) return (c == MAXC) ? c : c + 1;
    if (dn && !up) return (c == 0) ? 0 : c - 1;
    return c;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_wp = 0; m_rd = 0; m_owner = 0; m_phase = 0; m_age = 0;
    m_derr = 0; m_perr = 0;
  endtask

  // Phases: 0 owning, 1 draining, 2 switching.
  task automatic model_step();
    bit aw, wl, b, ar, rl, uf, dset, empty;
    int t;
    aw = awvalid && awready;
    wl = wvalid && wready && wlast;
    b  = bvalid && bready;
    ar = arvalid && arready;
    rl = rvalid && rready && rlast;
    uf = (b && !aw && m_wr == 0) || (wl && !aw && m_wp == 0) || (rl && !ar && m_rd == 0);
    empty = (m_wr == 0) && (m_wp == 0) && (m_rd == 0);
    t = tgt();
    dset = 0;
    case (m_phase)
      0: if (t != m_owner) begin m_phase = 1; m_age = 0; end
      1: begin
        m_age++;
        if (m_age == TMO) dset = 1;
        if (t == m_owner) m_phase = 0;
        else if (empty)   m_phase = 2;
      end
      default: begin m_owner = t; m_phase = 0; end
    endcase
    if (dset) m_derr = 1; else if (err_clr) m_derr = 0;
    if (uf)   m_perr = 1; else if (err_clr) m_perr = 0;
    m_wr = next_cnt(m_wr, aw, b);
    m_wp = next_cnt(m_wp, aw, wl);
    m_rd = next_cnt(m_rd, ar, rl);
  endtask

  task automatic check_all();
    check("owner", owner, m_owner);
    check("addr_block", addr_block, m_block());
    check("busy", busy, m_phase != 0);
    check("scrb_grant", scrb_grant, (m_phase == 0) && (m_owner == 2));
    check("atg_grant", atg_grant, (m_phase == 0) && (m_owner == 1));
    check("drain_err", drain_err, m_derr);
    check("proto_err", proto_err, m_perr);
    check("wr_outs", wr_outs, m_wr);
    check("rd_outs", rd_outs, m_rd);
    check("dbg_state_busy", dbg_state != ST_OWN, m_phase != 0);
  endtask

  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; arvalid = 0; arready = 0;
    rvalid = 0; rready = 0; rlast = 0; err_clr = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle();
    scrb_req = 0; atg_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check_all();
  endtask

  task automatic aw_beat();
    idle(); awvalid = 1; awready = 1; cycle(); idle();
  endtask

  initial begin
    // Idle reset state, then scrubber latency through DRAIN and SWITCH.
    do_reset();
    check("rst_owner", owner, 0);
    check("rst_addr_block", addr_block, 0);
    scrb_req = 1;
    cycle(); check("s1_drain_busy", busy, 1);
    cycle(); check("s1_switch_owner", owner, 0);
    cycle(); check("s1_owner", owner, 2); check("s1_grant", scrb_grant, 1);

    // SLV with 2 AW and 1 AR in flight, ATG request waits for the drain.
    do_reset();
    awvalid = 1; awready = 1; arvalid = 1; arready = 1; cycle();
    idle(); awvalid = 1; awready = 1; cycle();
    idle(); atg_req = 1; cycle();
    check("s2_block", addr_block, 1);
    repeat (2) begin idle(); wvalid = 1; wready = 1; wlast = 1; cycle(); end
    repeat (2) begin idle(); bvalid = 1; bready = 1; cycle(); end
    idle(); rvalid = 1; rready = 1; rlast = 1; cycle();
    idle(); check("s2_still_busy", busy, 1);
    cycle(); check("s2_switch_owner", owner, 0);
    cycle(); check("s2_owner", owner, 1); check("s2_grant", atg_grant, 1);

    // Scrubber overtakes ATG while draining: one switch straight to 2.
    do_reset();
    aw_beat();
    atg_req = 1; cycle();
    scrb_req = 1; cycle();
    wvalid = 1; wready = 1; wlast = 1; cycle();
    idle(); bvalid = 1; bready = 1; cycle();
    idle(); repeat (2) cycle();
    check("s3_owner", owner, 2);

    // Request withdrawn mid-drain with a burst still open.
    aw_beat();
    scrb_req = 0; cycle(); check("s4_drain", busy, 1);
    scrb_req = 1; cycle();
    check("s4_owner", owner, 2); check("s4_unblock", addr_block, 0);

    // Drain timeout: B withheld, flag set after 16 drain cycles.
    do_reset();
    aw_beat();
    atg_req = 1; cycle();
    repeat (TMO - 1) cycle();
    check("s5_no_err_yet", drain_err, 0);
    cycle(); check("s5_err", drain_err, 1); check("s5_in_drain", busy, 1);
    wvalid = 1; wready = 1; wlast = 1; bvalid = 1; bready = 1; cycle();
    idle(); repeat (2) cycle();
    check("s5_owner", owner, 1);
    err_clr = 1; cycle(); idle();
    check("s5_clr", drain_err, 0);

    // Spurious B, then fill the write counter to saturation.
    do_reset();
    bvalid = 1; bready = 1; cycle(); idle();
    check("s6_proto", proto_err, 1); check("s6_wr_zero", wr_outs, 0);
    for (int i = 0; i < MAXC + 4; i++) begin
      awvalid = !m_block(); awready = 1; cycle();
    end
    idle();
    check("s6_sat", wr_outs, MAXC); check("s6_block", addr_block, 1);

    // Random traffic; the bench plays the mux, gating AW/AR on addr_block.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4) scrb_req = ~scrb_req;
      if ($urandom_range(99) < 6) atg_req = ~atg_req;
      awvalid = !m_block() && ($urandom_range(3) == 0);
      awready = 1'($urandom_range(1));
      arvalid = !m_block() && ($urandom_range(3) == 0);
      arready = 1'($urandom_range(1));
      wvalid  = 1'($urandom_range(1));
      wready  = 1'($urandom_range(1));
      wlast   = (m_wp > 0) ? 1'($urandom_range(1)) : ($urandom_range(49) == 0);
      bvalid  = (m_wr > 0) ? ($urandom_range(2) == 0) : ($urandom_range(99) == 0);
      bready  = ($urandom_range(3) != 0);
      rvalid  = 1'($urandom_range(1));
      rready  = ($urandom_range(3) != 0);
      rlast   = (m_rd > 0) ? 1'($urandom_range(1)) : ($urandom_range(49) == 0);
      err_clr = ($urandom_range(29) == 0);
      cycle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
